// File: rtl/cart_pkg.sv
// cart_mapper shared types
// mapper ids and per-type power-up bank table
package cart_pkg;

  typedef enum logic [2:0] {
    MAP_UNKNOWN = 3'd0,
    MAP_NONE    = 3'd1,
    MAP_GM2     = 3'd2,
    MAP_KONAMI  = 3'd3,
    MAP_SCC     = 3'd4,
    MAP_ASCII8  = 3'd5,
    MAP_ASCII16 = 3'd6,
    MAP_RSVD    = 3'd7
  } mapper_e;

  typedef logic [3:0][7:0] banks_t;

  // id 7 behaves exactly like a plain ROM
  function automatic mapper_e norm_mapper(
    input logic [2:0] m
  );
    mapper_e t;
    t = mapper_e'(m);
    if (t == MAP_RSVD) t = MAP_NONE;
    return t;
  endfunction

  function automatic logic [7:0] default_bank(
    input mapper_e    m,
    input logic [1:0] page
  );
    logic [7:0] b;
    b = 8'd0;
    case (m)
      MAP_KONAMI,
      MAP_SCC,
      MAP_GM2:     b = {6'd0, page};
      MAP_ASCII16: b = {7'd0, page[0]};
      default:     b = 8'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cart_mapper_decode.sv
// cart_mapper write decoder
// maps a slot write to bank enables and data
module cart_mapper_decode
  import cart_pkg::*;
(
  input  mapper_e    mapper,
  input  logic [4:0] addr_hi,
  input  logic [7:0] d_from_cpu,
  output logic [3:0] we,
  output banks_t     wdata
);

  logic [7:0] d_lo;
  logic [7:0] d_hi;

  assign d_lo = {d_from_cpu[6:0], 1'b0};
  assign d_hi = {d_from_cpu[6:0], 1'b1};

  // per-type address window decode
  always_comb begin
    we    = 4'b0000;
    wdata = {4{d_from_cpu}};
    case (mapper)
      MAP_KONAMI: begin
        case (addr_hi[4:2])
          3'd3:    we[1] = 1'b1;
          3'd4:    we[2] = 1'b1;
          3'd5:    we[3] = 1'b1;
          default: we    = 4'b0000;
        endcase
      end
      MAP_SCC: begin
        if (addr_hi[1:0] == 2'b10) begin
          case (addr_hi[4:2])
            3'd2:    we[0] = 1'b1;
            3'd3:    we[1] = 1'b1;
            3'd4:    we[2] = 1'b1;
            3'd5:    we[3] = 1'b1;
            default: we    = 4'b0000;
          endcase
        end
      end
      MAP_ASCII8: begin
        if (addr_hi[4:2] == 3'd3)
          we[addr_hi[1:0]] = 1'b1;
      end
      MAP_ASCII16: begin
        wdata = {d_hi, d_lo, d_hi, d_lo};
        case (addr_hi)
          5'd12:   we = 4'b0011;
          5'd14:   we = 4'b1100;
          default: we = 4'b0000;
        endcase
      end
      MAP_GM2: begin
        wdata = {4{4'd0, d_from_cpu[3:0]}};
        case (addr_hi[4:1])
          4'd6:    we[1] = 1'b1;
          4'd8:    we[2] = 1'b1;
          4'd10:   we[3] = 1'b1;
          default: we    = 4'b0000;
        endcase
      end
      default: we = 4'b0000;
    endcase
  end

endmodule

// File: rtl/cart_mapper.sv
// cartridge bank-switching controller
// bank registers and CPU-to-ROM translation
module cart_mapper
  import cart_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] addr,
  input  logic        wr,
  input  logic        SLTSL_n,
  input  logic [7:0]  d_from_cpu,
  input  logic [2:0]  mapper,
  input  logic [3:0]  offset,
  input  logic [24:0] rom_size,
  input  logic        ioctl_isROM,
  input  logic [24:0] ioctl_addr,
  output logic [24:0] mem_addr,
  output logic        bank_wr,
  output logic        scc_sel
);

  banks_t     bank_q, bank_d;
  logic       wr_dly_q;
  mapper_e    map_q, map_n;
  logic       bank_wr_q, bank_wr_d;
  logic [3:0] we;
  banks_t     wdata;
  logic       wr_rise;
  logic       dflt;
  logic [1:0] page;
  logic [7:0] bank_sel;
  logic [24:0] banked;
  logic [24:0] plain;

  assign map_n   = norm_mapper(mapper);
  assign dflt    = ioctl_isROM | (map_n != map_q);
  assign wr_rise = wr & ~wr_dly_q
                 & ~SLTSL_n & ~ioctl_isROM;

  cart_mapper_decode u_dec (
    .mapper     (map_n),
    .addr_hi    (addr[15:11]),
    .d_from_cpu (d_from_cpu),
    .we         (we),
    .wdata      (wdata)
  );

  // defaults override any write in the same cycle
  always_comb begin
    bank_d    = bank_q;
    bank_wr_d = 1'b0;
    if (dflt) begin
      for (int i = 0; i < 4; i++)
        bank_d[i] = default_bank(map_n, 2'(i));
    end else if (wr_rise && (we != 4'b0000)) begin
      bank_wr_d = 1'b1;
      for (int i = 0; i < 4; i++)
        if (we[i]) bank_d[i] = wdata[i];
    end
  end

  // map_q starts unknown so the first clock loads defaults
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q    <= '0;
      wr_dly_q  <= 1'b0;
      map_q     <= MAP_UNKNOWN;
      bank_wr_q <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      wr_dly_q  <= wr;
      map_q     <= map_n;
      bank_wr_q <= bank_wr_d;
    end
  end

  // 8 KB page select; outside 4000-BFFF falls to bank0
  always_comb begin
    page = 2'd0;
    case (addr[15:13])
      3'd2:    page = 2'd0;
      3'd3:    page = 2'd1;
      3'd4:    page = 2'd2;
      3'd5:    page = 2'd3;
      default: page = 2'd0;
    endcase
  end

  assign bank_sel = bank_q[page];
  assign banked = {4'd0, bank_sel, addr[12:0]}
                & (rom_size - 25'd1);
  assign plain  = {9'd0, addr}
                - {9'd0, offset, 12'd0};

  // loader address wins, then plain or banked ROM
  always_comb begin
    mem_addr = banked;
    if (ioctl_isROM)
      mem_addr = ioctl_addr;
    else if (map_n == MAP_UNKNOWN ||
             map_n == MAP_NONE)
      mem_addr = plain;
  end

  assign bank_wr = bank_wr_q;
  assign scc_sel = (map_n == MAP_SCC)
                 & (bank_q[2][5:0] == 6'h3F)
                 & (addr[15:11] == 5'b10011)
                 & ~SLTSL_n;

endmodule
